// File: rtl/gon_xbus_arb_pkg.sv
// Shared GON bus definitions: default field widths and helpers used by the X/Y-bus blocks.
// A master ID of all ones (width ID_LEN) is the broadcast ID and matches any slave tag.
package gon_xbus_arb_pkg;

   localparam int GON_ID_LEN    = 5;
   localparam int GON_VALUE_LEN = 32;

   // True when two or more bits of v are set.
   function automatic logic gon_multi_hot(input logic [63:0] v);
      return |(v & (v - 64'd1));
   endfunction

endpackage

// File: rtl/gon_xbus_arb_if.sv
// X-bus port bundle: slave ready/tag in, registered value out, per-master enable/data and grant.
// The arbiter uses the slave modport; the master modport is the environment's view.
interface gon_xbus_arb_if #(
   parameter int MASTER_NUMS = 14,
   parameter int ID_LEN      = 5,
   parameter int VALUE_LEN   = 32
);
   logic [ID_LEN:0]                      ready_tag;
   logic [VALUE_LEN:0]                   enable_value;
   logic [MASTER_NUMS-1:0]               master_ready_tag;
   logic [(VALUE_LEN+1)*MASTER_NUMS-1:0] master_enable_data;

   modport slave  (input  ready_tag, master_enable_data,
                   output enable_value, master_ready_tag);
   modport master (output ready_tag, master_enable_data,
                   input  enable_value, master_ready_tag);
endinterface

// File: rtl/gon_xbus_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant (lowest request at/above ptr, wrapping); 0-cycle latency.
// ptr advances past the winner only when adv reports that the grant was taken.
module gon_rr_arbiter #(
   parameter int N = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] gidx;
   int            idx;

   // Scan from the farthest offset down so the nearest request at/after ptr is written last.
   always_comb begin
      gnt  = '0;
      gidx = '0;
      idx  = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gidx     = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (adv) begin
         ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
      end
   end

endmodule

// File: rtl/gon_xbus_arb.sv
// X-bus arbiter: ID-matched masters, round-robin grant, one-entry output register; grant->output 1 cycle.
// Grants only while the slave is ready, so a held output never changes under backpressure.
module gon_xbus_arb
   import gon_xbus_arb_pkg::*;
#(
   parameter int                MASTER_NUMS = 14,
   parameter int                ID_LEN      = GON_ID_LEN,
   parameter int                VALUE_LEN   = GON_VALUE_LEN,
   parameter int                MA_Y        = 0,
   parameter logic [ID_LEN-1:0] BCAST_ID    = {ID_LEN{1'b1}},
   parameter int                CNT_LEN     = 16
) (
   input  logic                clk,
   input  logic                rst,
   gon_xbus_arb_if.slave       bus,
   input  logic                set_id,
   input  logic [ID_LEN-1:0]   id_scan_in,
   output logic [ID_LEN-1:0]   id_scan_out,
   output logic [CNT_LEN-1:0]  conflict_cnt
);
   localparam int DW = VALUE_LEN + 1;

   logic [ID_LEN-1:0]      id_q [MASTER_NUMS];
   logic                   ready;
   logic [ID_LEN-1:0]      tag;
   logic [MASTER_NUMS-1:0] enable;
   logic [MASTER_NUMS-1:0] cand;
   logic [MASTER_NUMS-1:0] gnt;
   logic [VALUE_LEN-1:0]   value [MASTER_NUMS];
   logic [VALUE_LEN-1:0]   value_grant;
   logic [VALUE_LEN-1:0]   value_q;
   logic                   out_vld_q;
   logic                   m_xfer;
   logic                   s_xfer;
   logic [CNT_LEN-1:0]     cnt_q;

   assign ready = bus.ready_tag[ID_LEN];
   assign tag   = bus.ready_tag[ID_LEN-1:0];

   always_comb begin
      for (int i = 0; i < MASTER_NUMS; i++) begin
         enable[i] = bus.master_enable_data[i*DW + VALUE_LEN];
         value[i]  = bus.master_enable_data[i*DW +: VALUE_LEN];
         cand[i]   = ready & ((id_q[i] == tag) | (id_q[i] == BCAST_ID)) & enable[i] & ~set_id;
      end
   end

   gon_rr_arbiter #(.N(MASTER_NUMS)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (cand),
      .adv (m_xfer),
      .gnt (gnt)
   );

   always_comb begin
      value_grant = '0;
      for (int i = 0; i < MASTER_NUMS; i++) begin
         if (gnt[i]) value_grant = value_grant | value[i];
      end
   end

   assign m_xfer = |(enable & gnt);
   assign s_xfer = out_vld_q & ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MASTER_NUMS; i++) id_q[i] <= '0;
      end else if (set_id) begin
         id_q[0] <= id_scan_in;
         for (int i = 1; i < MASTER_NUMS; i++) id_q[i] <= id_q[i-1];
      end
   end

   // A refill in the same cycle as a drain keeps the register valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         value_q   <= '0;
      end else if (m_xfer) begin
         out_vld_q <= 1'b1;
         value_q   <= value_grant;
      end else if (s_xfer) begin
         out_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (gon_multi_hot(64'(cand)) && (cnt_q != {CNT_LEN{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.enable_value     = {out_vld_q, value_q};
   assign bus.master_ready_tag = gnt;
   assign id_scan_out          = id_q[MASTER_NUMS-1];
   assign conflict_cnt         = cnt_q;

endmodule
